// File: rtl/gpio_status_out.sv
// Status-to-pad driver: registered busy, stretched done pulse with one-deep pending, optional sticky irq.
// Optional sticky interrupt enabled by defining GPIO_STATUS_IRQ_EN.
module gpio_status_out #(
    parameter int DONE_WIDTH = 8,
    parameter int GAP_WIDTH  = 2
) (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic core_busy,
    input  logic core_done,
    input  logic irq_clr,
    output logic gpio_busy,
    output logic gpio_done,
    output logic gpio_irq
);

    localparam logic [7:0] LP_DONE_LOAD = 8'(DONE_WIDTH - 1);
    localparam logic [7:0] LP_GAP_LOAD  = 8'(GAP_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_pend;
    logic       w_pend_nxt;
    logic       r_busy;
    logic       r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        case (r_state)
            ST_IDLE: begin
                if (core_done) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = LP_DONE_LOAD;
                end
            end
            ST_PULSE: begin
                // A second event while one is already pending is simply absorbed.
                if (core_done) begin
                    w_pend_nxt = 1'b1;
                end
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = LP_GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_GAP: begin
                if (r_cnt == 8'd0) begin
                    if (r_pend) begin
                        w_state_nxt = ST_PULSE;
                        w_cnt_nxt   = LP_DONE_LOAD;
                        w_pend_nxt  = core_done;
                    end else if (core_done) begin
                        w_state_nxt = ST_PULSE;
                        w_cnt_nxt   = LP_DONE_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                    if (core_done) begin
                        w_pend_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_busy  <= core_busy;
            r_done  <= (w_state_nxt == ST_PULSE);
        end
    end

    assign gpio_busy = r_busy;
    assign gpio_done = r_done;

`ifdef GPIO_STATUS_IRQ_EN
    logic r_irq;

    // Set has priority so a completion coinciding with a clear is never lost.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_irq <= 1'b0;
        end else if (ena) begin
            if (core_done) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign gpio_irq = r_irq;
`else
    logic w_irq_clr_unused;

    assign w_irq_clr_unused = irq_clr;
    assign gpio_irq         = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_status_out.sv
// Scoreboard bench for gpio_status_out: a pulse-schedule reference model predicts each cycle's outputs.
module tb_gpio_status_out;

    localparam int DW = 8;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic ena = 1'b0;
    logic core_busy = 1'b0;
    logic core_done = 1'b0;
    logic irq_clr = 1'b0;
    logic gpio_busy;
    logic gpio_done;
    logic gpio_irq;

    gpio_status_out #(.DONE_WIDTH(DW), .GAP_WIDTH(GW)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .core_busy (core_busy),
        .core_done (core_done),
        .irq_clr   (irq_clr),
        .gpio_busy (gpio_busy),
        .gpio_done (gpio_done),
        .gpio_irq  (gpio_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busy;
        logic done;
        logic irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model in terms of enabled-edge indices: each accepted event
    // becomes a pulse start time; a new pulse may start no earlier than
    // previous start + DW + GW, and at most one event waits for that slot.
    int   m_n;
    int   m_last_start;
    int   m_next_ok;
    bit   m_has_start;
    bit   m_pend;
    exp_t m_exp;

    task automatic check(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    function automatic void model_reset();
        m_n          = 0;
        m_last_start = 0;
        m_next_ok    = 0;
        m_has_start  = 1'b0;
        m_pend       = 1'b0;
        m_exp        = '0;
    endfunction

    function automatic void model_edge(input logic e, input logic b, input logic d, input logic c);
        if (!e) return;
        m_n++;
        m_exp.busy = b;
        if (m_pend && m_n == m_next_ok) begin
            m_last_start = m_n;
            m_next_ok    = m_n + DW + GW;
            m_has_start  = 1'b1;
            m_pend       = 1'b0;
        end
        if (d) begin
            if (!m_pend && m_n >= m_next_ok) begin
                m_last_start = m_n;
                m_next_ok    = m_n + DW + GW;
                m_has_start  = 1'b1;
            end else if (!m_pend) begin
                m_pend = 1'b1;
            end
        end
        m_exp.done = m_has_start && (m_n >= m_last_start) && (m_n <= m_last_start + DW - 1);
`ifdef GPIO_STATUS_IRQ_EN
        if (d) m_exp.irq = 1'b1;
        else if (c) m_exp.irq = 1'b0;
`else
        m_exp.irq = 1'b0;
        if (c) m_exp.irq = 1'b0;
`endif
    endfunction

    task automatic step(input logic e, input logic b, input logic d, input logic c);
        @(negedge clk);
        ena       = e;
        core_busy = b;
        core_done = d;
        irq_clr   = c;
        model_edge(e, b, d, c);
        exp_q.push_back(m_exp);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        ena       = 1'b0;
        core_busy = 1'b0;
        core_done = 1'b0;
        irq_clr   = 1'b0;
        rstb      = 1'b0;
        #1;
        check("rst_busy", gpio_busy, 1'b0);
        check("rst_done", gpio_done, 1'b0);
        check("rst_irq", gpio_irq, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    // Monitor: outputs are presented every clock, so each posedge retires one prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("busy", gpio_busy, e.busy);
                check("done", gpio_done, e.done);
                check("irq", gpio_irq, e.irq);
            end
        end
    end

    initial begin
        model_reset();
        #1;
        check("init_done", gpio_done, 1'b0);
        check("init_irq", gpio_irq, 1'b0);
        do_reset();
        idle(3);

        // single pulse
        step(1, 1, 1, 0);
        idle(14);
        // two events three cycles apart
        step(1, 0, 1, 0);
        idle(2);
        step(1, 1, 1, 0);
        idle(24);
        // three events inside one pulse window
        step(1, 0, 1, 0);
        idle(1);
        step(1, 0, 1, 0);
        idle(1);
        step(1, 0, 1, 0);
        idle(26);
        // event exactly on the gap-end edge
        step(1, 0, 1, 0);
        idle(DW + GW - 1);
        step(1, 0, 1, 0);
        idle(14);
        // freeze mid-pulse with events during the freeze
        step(1, 0, 1, 0);
        idle(3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, (i % 2 == 0), 1'b1);
        idle(16);
        // irq set/clear interactions
        step(1, 0, 1, 1);
        idle(2);
        step(1, 0, 0, 1);
        idle(12);
        // reset mid-pulse with an event pending
        step(1, 0, 1, 0);
        idle(1);
        step(1, 0, 1, 0);
        idle(2);
        do_reset();
        idle(25);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            end
        end
        idle(4);

        repeat (2) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
